// File: rtl/ecg_peak_detector_if.sv
// Sample-side bundle for ecg_peak_detector: strobe/sample/threshold in,
// filtered stream, peak strobe and R-R interval out.
interface ecg_peak_detector_if #(
  parameter int DATA_W = 12
);
  logic              sampleEn;
  logic [DATA_W-1:0] sampleIn;
  logic [DATA_W-1:0] threshold;
  logic [DATA_W-1:0] filtOut;
  logic              filtValid;
  logic              peakPulse;
  logic [15:0]       rrInterval;
  logic              rrValid;

  // Sample source / heart-rate consumer side
  modport master (
    output sampleEn, sampleIn, threshold,
    input  filtOut, filtValid, peakPulse, rrInterval, rrValid
  );

  // Detector side
  modport slave (
    input  sampleEn, sampleIn, threshold,
    output filtOut, filtValid, peakPulse, rrInterval, rrValid
  );
endinterface

// File: rtl/ecg_peak_detector.sv
// ECG R-peak detector: moving-average filter (2^AVG_LOG2 window) feeding a
// three-state peak FSM with a refractory window and a saturating R-R counter.
// Runs on bigClk; new samples are qualified by the one-cycle sampleEn strobe.
module ecg_peak_detector #(
  parameter int DATA_W   = 12,
  parameter int AVG_LOG2 = 3,
  parameter int REFRACT  = 50
) (
  input  logic                bigClk,
  input  logic                rst,
  ecg_peak_detector_if.slave  bus
);

  localparam int unsigned WIN   = 1 << AVG_LOG2;
  localparam int          PTR_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int          SUM_W = DATA_W + AVG_LOG2;
  localparam int          REF_W = $clog2(REFRACT + 1);
  // Window of one entry: pointer never moves
  localparam logic [PTR_W-1:0] PTR_STEP = (AVG_LOG2 > 0) ? PTR_W'(1) : '0;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RISING  = 2'd1;
  localparam logic [1:0] ST_REFRACT = 2'd2;

  // Filter state
  logic [DATA_W-1:0] r_buf [WIN];
  logic [PTR_W-1:0]  r_ptr;
  logic [SUM_W-1:0]  r_sum;
  logic [DATA_W-1:0] r_filtOut;
  logic              r_filtValid;

  // Peak / R-R state
  logic [1:0]        r_state;
  logic [DATA_W-1:0] r_prevFilt;
  logic [15:0]       r_sinceCnt;
  logic [REF_W-1:0]  r_refCnt;
  logic              r_havePeak;
  logic              r_peakPulse;
  logic              r_rrValid;
  logic [15:0]       r_rrInterval;

  logic [SUM_W-1:0]  w_sum_next;
  logic [DATA_W-1:0] w_filt_next;
  logic              w_detect;
  logic [15:0]       w_since_inc;

  // Running-sum update and averaged output for the incoming sample
  always_comb begin
    w_sum_next  = r_sum + SUM_W'(bus.sampleIn) - SUM_W'(r_buf[r_ptr]);
    w_filt_next = DATA_W'(w_sum_next >> AVG_LOG2);
  end

  // Detection decision and saturating interval increment
  always_comb begin
    w_detect    = r_filtValid && (r_state == ST_RISING) && (r_filtOut < r_prevFilt);
    w_since_inc = (r_sinceCnt == 16'hFFFF) ? r_sinceCnt : r_sinceCnt + 16'd1;
  end

  // Moving-average filter: circular buffer, running sum, registered output
  always_ff @(posedge bigClk) begin
    if (rst) begin
      r_buf       <= '{default: '0};
      r_ptr       <= '0;
      r_sum       <= '0;
      r_filtOut   <= '0;
      r_filtValid <= 1'b0;
    end else begin
      r_filtValid <= bus.sampleEn;
      if (bus.sampleEn) begin
        r_sum        <= w_sum_next;
        r_buf[r_ptr] <= bus.sampleIn;
        r_ptr        <= r_ptr + PTR_STEP;
        r_filtOut    <= w_filt_next;
      end
    end
  end

  // Peak FSM, refractory counter and R-R interval, advanced per filtered sample
  always_ff @(posedge bigClk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_prevFilt   <= '0;
      r_sinceCnt   <= '0;
      r_refCnt     <= '0;
      r_havePeak   <= 1'b0;
      r_peakPulse  <= 1'b0;
      r_rrValid    <= 1'b0;
      r_rrInterval <= '0;
    end else begin
      r_peakPulse <= w_detect;
      r_rrValid   <= w_detect && r_havePeak;
      if (r_filtValid) begin
        r_prevFilt <= r_filtOut;
        if (w_detect) begin
          r_rrInterval <= w_since_inc;
          r_sinceCnt   <= '0;
          r_havePeak   <= 1'b1;
        end else begin
          r_sinceCnt <= w_since_inc;
        end
        case (r_state)
          ST_IDLE: begin
            if (r_filtOut >= bus.threshold) r_state <= ST_RISING;
          end
          ST_RISING: begin
            if (w_detect) begin
              r_refCnt <= REF_W'(REFRACT);
              r_state  <= ST_REFRACT;
            end
          end
          ST_REFRACT: begin
            if (r_refCnt != '0) begin
              r_refCnt <= r_refCnt - 1'b1;
            end else if (r_filtOut < bus.threshold) begin
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.filtOut    = r_filtOut;
  assign bus.filtValid  = r_filtValid;
  assign bus.peakPulse  = r_peakPulse;
  assign bus.rrInterval = r_rrInterval;
  assign bus.rrValid    = r_rrValid;

endmodule

// File: doc/ecg_peak_detector.md
# ecg_peak_detector

Consumes the slow-rate ECG sample stream paced by the clock divider and produces a smoothed signal, R-peak pulses and R-R intervals for downstream heart-rate logic. It runs on the fast system clock and uses a one-cycle sample strobe (`sampleEn`) instead of a second clock domain. A moving-average filter feeds a three-state peak FSM with a refractory window. The block sits between the sample source (ADC/ROM reader) and the heart-rate computation.

## Interface
- `DATA_W`, default 12: unsigned sample width.
- `AVG_LOG2`, default 3: log2 of the averaging window (window = 2^AVG_LOG2). 0 is legal and means pass-through.
- `REFRACT`, default 50: refractory length in filtered samples, at least 1.
- `bigClk`  in  1: system clock. Everything is clocked on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `sampleEn`  in  1: one-cycle strobe marking a new sample. May be asserted every cycle.
- `sampleIn`  in  DATA_W: unsigned sample, valid when `sampleEn`=1.
- `threshold`  in  DATA_W: detection level. Static during operation.
- `filtOut`  out  DATA_W: averaged sample.
- `filtValid`  out  1: one-cycle strobe qualifying `filtOut`.
- `peakPulse`  out  1: one-cycle strobe on each R-peak detection.
- `rrInterval`  out  16: filtered samples between the last two detections.
- `rrValid`  out  1: one-cycle strobe qualifying `rrInterval`.

## Operation
- **Filter**
  - Circular buffer of 2^AVG_LOG2 entries, DATA_W wide, with a write pointer that wraps modulo the window.
  - Running sum is DATA_W+AVG_LOG2 bits. On `sampleEn`: `sum <= sum + sampleIn - buf[ptr]`, `buf[ptr] <= sampleIn`, `ptr` increments.
  - `filtOut` is the new sum >> AVG_LOG2, truncated. The sum can never overflow.
  - The buffer is zero after reset, so the first 2^AVG_LOG2-1 outputs include zeros (warm-up). This is intended.
- **Peak FSM** (state changes only on cycles with `filtValid`=1; `prevFilt` is the previous `filtOut`)
  - IDLE: if `filtOut` >= `threshold`, go to RISING.
  - RISING: if `filtOut` < `prevFilt`, this is a detection. Assert `peakPulse`, load `refCnt=REFRACT`, go to REFRACT. Otherwise stay in RISING.
  - REFRACT: if `refCnt`!=0, decrement it. If `refCnt`==0 and `filtOut` < `threshold`, go to IDLE. No detections occur in this state.
- **R-R counter** (`sinceCnt`, 16 bits)
  - On each filtValid that is a detection: `rrInterval <= sat(sinceCnt+1)` and `sinceCnt <= 0`.
  - On each filtValid that is not a detection: `sinceCnt <= sat(sinceCnt+1)`.
  - Saturation is at 0xFFFF, with no wrap.
  - `rrValid` pulses together with `peakPulse`, except on the first detection after reset (a `havePeak` flag is cleared by reset).
- **Reset** (any cycle, including mid-window or mid-refractory)
  - Clears the buffer, sum, pointer, `prevFilt`, `sinceCnt`, `refCnt`, `havePeak` and the FSM (to IDLE).
  - All outputs go to 0 on the next edge.
  - A `sampleEn` in the same cycle as `rst` is dropped.

## Timing
- Reset value of every output: 0.
- `filtValid`/`filtOut`: registered, 1 cycle after `sampleEn`. `filtOut` holds its value between strobes.
- `peakPulse`, `rrValid`, `rrInterval`: registered, 1 cycle after the `filtValid` cycle that detected the peak (2 cycles after its `sampleEn`). `rrInterval` holds its value until the next update.
- Back-to-back `sampleEn` (every cycle) is fully pipelined: one output per cycle, no stall, no loss.
- Simultaneous `filtValid` and `rst`: reset wins, no pulse is emitted.

## Test plan
- **Warm-up and average:** defaults, `threshold`=1000, 10 strobes of `sampleIn`=800.
  - `filtOut` = 100, 200, …, 800, then stays at 800.
  - Each `filtValid` arrives 1 cycle after its strobe.
  - No `peakPulse`.
- **Pointer wrap:** continue the previous case with 8 strobes of 0.
  - `filtOut` = 700, 600, …, 0.
  - A 9th strobe of 0 keeps `filtOut` at 0 (buffer fully overwritten).
- **Single peak:** `AVG_LOG2`=0, `threshold`=1000, inputs 500, 1200, 1500, 1400.
  - `peakPulse` is high exactly 1 cycle after the `filtValid` of 1400.
  - `rrValid` stays 0 (first peak).
- **Refractory and R-R:** `AVG_LOG2`=0, `REFRACT`=5, samples 1..200 all at 0.
  - Exceptions: samples 3..4 = 1500, 1400; samples 6..7 = 1600, 1300 (inside refractory); samples 63..64 = 1500, 1400.
  - Exactly two `peakPulse`s, at samples 4 and 64.
  - The second carries `rrValid`=1 with `rrInterval`=60.
- **Throughput and reset:** `sampleEn` held high for 20 cycles with a ramp input, then `rst` asserted for 1 cycle mid-refractory.
  - One `filtValid` per cycle during the burst.
  - All outputs are 0 the cycle after `rst`.
  - FSM is in IDLE and the next detection has `rrValid`=0.
- **Saturation:** one peak, then 70000 sub-threshold samples, then a second peak.
  - `rrInterval`=0xFFFF with `rrValid`=1.
